// File: rtl/brew_fsm_param.sv
// Brewing-kettle sequencer: optional disposal/sterilise/cool pre-clean, fill,
// timed mash with hysteresis heat hold, configurable sparge rounds, final
// drain, and an over-temperature lock-out that only reset clears.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-low reset
//   start   - begin a brew (sampled only in IDLE)
//   temp    - unsigned temperature sensor, W bits
//   level   - unsigned level sensor, W bits
//   heat    - heater enable
//   agitate - agitator enable
//   chute   - grain chute open (one-cycle pulse on mash entry)
//   pump    - valve code: OFF=000 WASTE=010 TO_TANK=011 WATER=100 SPARGE=111
//   state   - current state code
//   busy    - state != IDLE
//   done    - one-cycle brew-complete pulse
//   fault   - over-temperature lock-out
// All outputs are registered.
module brew_fsm_param #(
  parameter int unsigned W              = 8,
  parameter int unsigned T_SAFE         = 30,
  parameter int unsigned T_PROCESS      = 60,
  parameter int unsigned T_HYST         = 5,
  parameter int unsigned T_STERILE      = 80,
  parameter int unsigned T_MAX          = 110,
  parameter int unsigned L_PREPARE      = 125,
  parameter int unsigned L_SPARGE_START = 70,
  parameter int unsigned L_SPARGE_END   = 40,
  parameter int unsigned L_DRAINED      = 20,
  parameter int unsigned MASH_CYCLES    = 60,
  parameter int unsigned SPARGE_ROUNDS  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] temp,
  input  logic [W-1:0] level,
  output logic         heat,
  output logic         agitate,
  output logic         chute,
  output logic [2:0]   pump,
  output logic [3:0]   state,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  localparam int unsigned TW = $clog2(MASH_CYCLES + 1);
  localparam int unsigned RW = (SPARGE_ROUNDS == 0) ? 1 : $clog2(SPARGE_ROUNDS + 1);

  localparam logic [2:0] PUMP_OFF     = 3'b000;
  localparam logic [2:0] PUMP_WASTE   = 3'b010;
  localparam logic [2:0] PUMP_TO_TANK = 3'b011;
  localparam logic [2:0] PUMP_WATER   = 3'b100;
  localparam logic [2:0] PUMP_SPARGE  = 3'b111;

  // Upper hysteresis bound kept one bit wider so it cannot wrap.
  localparam logic [W:0] MASH_HI = (W+1)'(T_PROCESS) + (W+1)'(T_HYST);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    DISPOSAL     = 4'd1,
    STERILISE    = 4'd2,
    COOL         = 4'd3,
    FILL         = 4'd4,
    MASH         = 4'd5,
    SPARGE_DRAIN = 4'd6,
    SPARGE_RINSE = 4'd7,
    DONE         = 4'd8,
    FAULT        = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic          heat_q, heat_d;
  logic          agitate_q, agitate_d;
  logic          chute_q, chute_d;
  logic [2:0]    pump_q, pump_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic over_temp;
  logic level_full;

  assign over_temp  = temp >= W'(T_MAX);
  assign level_full = level >= W'(L_PREPARE);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rounds_q  <= '0;
      heat_q    <= 1'b0;
      agitate_q <= 1'b0;
      chute_q   <= 1'b0;
      pump_q    <= PUMP_OFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rounds_q  <= rounds_d;
      heat_q    <= heat_d;
      agitate_q <= agitate_d;
      chute_q   <= chute_d;
      pump_q    <= pump_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state and next-output logic; over-temperature overrides everything.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rounds_d  = rounds_q;
    heat_d    = heat_q;
    agitate_d = agitate_q;
    chute_d   = 1'b0;
    pump_d    = pump_q;
    done_d    = 1'b0;
    fault_d   = fault_q;

    if (state_q != IDLE && state_q != FAULT && over_temp) begin
      state_d   = FAULT;
      heat_d    = 1'b0;
      agitate_d = 1'b0;
      pump_d    = PUMP_OFF;
      fault_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          heat_d    = 1'b0;
          agitate_d = 1'b0;
          pump_d    = PUMP_OFF;
          if (start) begin
            if (level == '0) begin
              state_d = FILL;
              pump_d  = PUMP_WATER;
              heat_d  = 1'b1;
            end else begin
              state_d = DISPOSAL;
              pump_d  = PUMP_WASTE;
            end
          end
        end
        DISPOSAL: begin
          if (level == '0) begin
            state_d = STERILISE;
            pump_d  = PUMP_OFF;
            heat_d  = 1'b1;
          end
        end
        STERILISE: begin
          if (temp >= W'(T_STERILE)) begin
            state_d = COOL;
            heat_d  = 1'b0;
          end
        end
        COOL: begin
          if (temp <= W'(T_SAFE)) begin
            state_d = FILL;
            pump_d  = PUMP_WATER;
            heat_d  = 1'b1;
          end
        end
        FILL: begin
          // pump==OFF inside FILL remembers that the fill level was reached.
          if (level_full) pump_d = PUMP_OFF;
          if ((level_full || pump_q == PUMP_OFF) && temp >= W'(T_PROCESS)) begin
            state_d   = MASH;
            chute_d   = 1'b1;
            agitate_d = 1'b1;
            timer_d   = TW'(MASH_CYCLES - 1);
          end
        end
        MASH: begin
          if (timer_q == '0) begin
            state_d   = SPARGE_DRAIN;
            heat_d    = 1'b0;
            agitate_d = 1'b0;
            pump_d    = PUMP_TO_TANK;
            rounds_d  = '0;
          end else begin
            timer_d = timer_q - TW'(1);
            if ({1'b0, temp} >= MASH_HI)        heat_d = 1'b0;
            else if (temp < W'(T_PROCESS))      heat_d = 1'b1;
          end
        end
        SPARGE_DRAIN: begin
          if (rounds_q == RW'(SPARGE_ROUNDS)) begin
            if (level < W'(L_DRAINED)) begin
              state_d = DONE;
              pump_d  = PUMP_OFF;
              done_d  = 1'b1;
            end
          end else if (level < W'(L_SPARGE_END)) begin
            state_d = SPARGE_RINSE;
            pump_d  = PUMP_SPARGE;
          end
        end
        SPARGE_RINSE: begin
          if (level >= W'(L_SPARGE_START)) begin
            state_d  = SPARGE_DRAIN;
            pump_d   = PUMP_TO_TANK;
            rounds_d = rounds_q + RW'(1);
          end
        end
        DONE: begin
          state_d   = IDLE;
          heat_d    = 1'b0;
          agitate_d = 1'b0;
          pump_d    = PUMP_OFF;
        end
        FAULT: begin
          heat_d    = 1'b0;
          agitate_d = 1'b0;
          pump_d    = PUMP_OFF;
          fault_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign state   = state_q;
  assign heat    = heat_q;
  assign agitate = agitate_q;
  assign chute   = chute_q;
  assign pump    = pump_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_brew_fsm_param.sv
// Randomised, sensor-steered bench for brew_fsm_param (MASH_CYCLES=4,
// SPARGE_ROUNDS=2) checked every cycle against a behavioural model of the
// brewing recipe, including over-temperature trips and asynchronous resets.
module tb_brew_fsm_param;

  localparam int MASH_CYCLES    = 4;
  localparam int SPARGE_ROUNDS  = 2;
  localparam int T_SAFE         = 30;
  localparam int T_PROCESS      = 60;
  localparam int T_HYST         = 5;
  localparam int T_STERILE      = 80;
  localparam int T_MAX          = 110;
  localparam int L_PREPARE      = 125;
  localparam int L_SPARGE_START = 70;
  localparam int L_SPARGE_END   = 40;
  localparam int L_DRAINED      = 20;
  localparam int N_CYCLES       = 4000;

  // Recipe phases by their published codes.
  localparam int S_IDLE = 0, S_DISP = 1, S_STER = 2, S_COOL = 3, S_FILL = 4;
  localparam int S_MASH = 5, S_DRAIN = 6, S_RINSE = 7, S_DONE = 8, S_FAULT = 9;
  localparam int P_OFF = 0, P_WASTE = 2, P_TO_TANK = 3, P_WATER = 4, P_SPARGE = 7;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] temp;
  logic [7:0] level;
  logic       heat, agitate, chute, busy, done, fault;
  logic [2:0] pump;
  logic [3:0] state;

  brew_fsm_param #(
    .MASH_CYCLES  (MASH_CYCLES),
    .SPARGE_ROUNDS(SPARGE_ROUNDS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .temp   (temp),
    .level  (level),
    .heat   (heat),
    .agitate(agitate),
    .chute  (chute),
    .pump   (pump),
    .state  (state),
    .busy   (busy),
    .done   (done),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the expected recipe outputs.
  int m_st, m_pump, m_rounds, m_mash_left;
  bit m_heat, m_agit, m_chute, m_done, m_fault, m_filled;
  int t_i = 25;
  int l_i = 0;
  int fault_cycles = 0;
  int n_brews = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},   32'(state),   32'(m_st));
    check({tag, ".heat"},    32'(heat),    32'(m_heat));
    check({tag, ".agitate"}, 32'(agitate), 32'(m_agit));
    check({tag, ".chute"},   32'(chute),   32'(m_chute));
    check({tag, ".pump"},    32'(pump),    32'(m_pump));
    check({tag, ".busy"},    32'(busy),    32'(m_st != S_IDLE));
    check({tag, ".done"},    32'(done),    32'(m_done));
    check({tag, ".fault"},   32'(fault),   32'(m_fault));
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pump = P_OFF; m_rounds = 0; m_mash_left = 0;
    m_heat = 0; m_agit = 0; m_chute = 0; m_done = 0; m_fault = 0; m_filled = 0;
  endtask

  // One clock of the recipe given the sensor values sampled on that edge.
  task automatic model_step(input bit s, input int t, input int l);
    m_done  = 0;
    m_chute = 0;
    if (m_st != S_IDLE && m_st != S_FAULT && t >= T_MAX) begin
      m_st = S_FAULT; m_heat = 0; m_agit = 0; m_pump = P_OFF; m_fault = 1;
      return;
    end
    case (m_st)
      S_IDLE: if (s) begin
        if (l == 0) begin m_st = S_FILL; m_pump = P_WATER; m_heat = 1; m_filled = 0; end
        else begin m_st = S_DISP; m_pump = P_WASTE; end
      end
      S_DISP: if (l == 0) begin m_st = S_STER; m_pump = P_OFF; m_heat = 1; end
      S_STER: if (t >= T_STERILE) begin m_st = S_COOL; m_heat = 0; end
      S_COOL: if (t <= T_SAFE) begin m_st = S_FILL; m_pump = P_WATER; m_heat = 1; m_filled = 0; end
      S_FILL: begin
        if (l >= L_PREPARE) begin m_filled = 1; m_pump = P_OFF; end
        if (m_filled && t >= T_PROCESS) begin
          m_st = S_MASH; m_chute = 1; m_agit = 1; m_mash_left = MASH_CYCLES;
        end
      end
      S_MASH: begin
        m_mash_left--;
        if (m_mash_left == 0) begin
          m_st = S_DRAIN; m_heat = 0; m_agit = 0; m_pump = P_TO_TANK; m_rounds = 0;
        end else if (t >= T_PROCESS + T_HYST) m_heat = 0;
        else if (t < T_PROCESS) m_heat = 1;
      end
      S_DRAIN: begin
        if (m_rounds == SPARGE_ROUNDS) begin
          if (l < L_DRAINED) begin m_st = S_DONE; m_pump = P_OFF; m_done = 1; n_brews++; end
        end else if (l < L_SPARGE_END) begin
          m_st = S_RINSE; m_pump = P_SPARGE;
        end
      end
      S_RINSE: if (l >= L_SPARGE_START) begin m_st = S_DRAIN; m_pump = P_TO_TANK; m_rounds++; end
      S_DONE: m_st = S_IDLE;
      default: ;
    endcase
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Sensor values drift towards whatever the current phase is waiting for.
  task automatic drive_inputs();
    int t, l;
    t = t_i;
    l = l_i;
    start = ($urandom_range(0, 2) == 0);
    case (m_st)
      S_IDLE: begin
        l = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 60));
        t = $urandom_range(10, 60);
      end
      S_DISP:  l = clamp(l - int'($urandom_range(0, 15)), 0, 255);
      S_STER:  t = clamp(t + int'($urandom_range(0, 10)), 0, 100);
      S_COOL:  t = clamp(t - int'($urandom_range(0, 10)), 0, 255);
      S_FILL: begin
        l = clamp(l + int'($urandom_range(0, 15)), 0, 200);
        t = clamp(t + int'($urandom_range(0, 6)) - 2, 0, 100);
      end
      S_MASH:  t = $urandom_range(52, 72);
      S_DRAIN: l = clamp(l - int'($urandom_range(0, 6)), 0, 255);
      S_RINSE: l = clamp(l + int'($urandom_range(0, 6)), 0, 120);
      default: begin
        t = $urandom_range(0, 120);
        l = $urandom_range(0, 255);
      end
    endcase
    if (m_st != S_IDLE && m_st != S_FAULT && $urandom_range(0, 299) == 0)
      t = $urandom_range(T_MAX, 255);
    t_i = t;
    l_i = l;
    temp  = 8'(t);
    level = 8'(l);
  endtask

  // Reset asserted between clock edges must clear outputs without a clock.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    temp  = 8'(t_i);
    level = 8'(l_i);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    drive_inputs();
    model_step(start, t_i, l_i);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      check_all("run");
      fault_cycles = (m_st == S_FAULT) ? fault_cycles + 1 : 0;
      if (fault_cycles >= 6 || $urandom_range(0, 599) == 0) begin
        async_reset();
        fault_cycles = 0;
      end
      drive_inputs();
      model_step(start, t_i, l_i);
    end

    $display("completed brews in run: %0d", n_brews);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
